sse_uv_feeder: RTL

- Requester-side front end for the chroma SSE engine.
- Accepts source/prediction pixel rows one per handshake and packs BLOCK_SIZE rows into the engine's flattened a/b buses.
- Issues a single-cycle start, waits for the engine's done, captures the 32-bit SSE and returns it on a valid/ready result port.
- Sits between the macroblock row buffer and the SSE engine in the UV mode-decision path.

---
 rtl/sse_uv_feeder_if.sv | 41 ++++
 rtl/sse_uv_feeder.sv | 135 +++++++++++++
 2 files changed

// File: rtl/sse_uv_feeder_if.sv
// Bus bundle between the row buffer, the SSE engine and the result consumer.
// The master modport is the feeder's own view. The slave modport is the view
// of the surrounding environment.
interface sse_uv_feeder_if #(
  parameter int BIT_WIDTH  = 8,
  parameter int BLOCK_SIZE = 8,
  parameter int ROW_PIX    = 16
);
  localparam int ROW_W = BIT_WIDTH * ROW_PIX;
  localparam int BLK_W = ROW_W * BLOCK_SIZE;

  // Row intake
  logic             in_valid;
  logic             in_ready;
  logic [ROW_W-1:0] in_src;
  logic [ROW_W-1:0] in_pred;

  // Engine request/response
  logic             sse_start;
  logic [BLK_W-1:0] sse_a;
  logic [BLK_W-1:0] sse_b;
  logic             sse_done;
  logic [31:0]      sse_in;

  // Result return
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_sse;
  logic             res_err;
  logic             busy;

  modport master (
    input  in_valid, in_src, in_pred, sse_done, sse_in, res_ready,
    output in_ready, sse_start, sse_a, sse_b, res_valid, res_sse, res_err, busy
  );

  modport slave (
    output in_valid, in_src, in_pred, sse_done, sse_in, res_ready,
    input  in_ready, sse_start, sse_a, sse_b, res_valid, res_sse, res_err, busy
  );
endinterface

// File: rtl/sse_uv_feeder.sv
// Chroma SSE requester front end. It packs BLOCK_SIZE rows into the engine's
// a/b buses, pulses start, waits for done and returns the SSE on a
// valid/ready port.
// Optional watchdog: define SSE_FEEDER_TIMEOUT_EN to abort a WAIT after
// TIMEOUT cycles. The abort reports res_err=1 and res_sse=0.
module sse_uv_feeder #(
  parameter int BIT_WIDTH  = 8,
  parameter int BLOCK_SIZE = 8,
  parameter int ROW_PIX    = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic            clk,
  input  logic            rst,
  sse_uv_feeder_if.master bus
);
  localparam int ROW_W = BIT_WIDTH * ROW_PIX;
  localparam int BLK_W = ROW_W * BLOCK_SIZE;
  localparam int CNT_W = $clog2(BLOCK_SIZE);

  if (BLOCK_SIZE < 2 || BLOCK_SIZE > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("sse_uv_feeder: BLOCK_SIZE must be 2..8 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {FILL, START, WAIT, OUT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [BLK_W-1:0] a_q, b_q;
  logic [31:0]      sse_q;
  logic             accept;
  logic             last_row;
  logic             done_hit;
  logic             wd_expired;

  // Rows are only consumed in FILL. Every other state ignores in_valid.
  assign accept   = (state_q == FILL) && bus.in_valid;
  assign last_row = (row_q == CNT_W'(BLOCK_SIZE - 1));
  // A done pulse outside WAIT is stray and must not capture anything.
  assign done_hit = (state_q == WAIT) && bus.sse_done;

`ifdef SSE_FEEDER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q;

  // A real done in the same cycle as the expiry wins over the watchdog.
  assign wd_expired = (state_q == WAIT) && !bus.sse_done &&
                      (wd_q == WD_W'(TIMEOUT - 1));

  // Watchdog counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end

  // Clear the counter in START so it counts WAIT cycles from entry
  always_comb begin
    wd_d = wd_q;
    if (state_q == START)     wd_d = '0;
    else if (state_q == WAIT) wd_d = wd_q + 1'b1;
  end

  // The error flag is set by an expiry and cleared by a genuine done
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             err_q <= 1'b0;
    else if (done_hit)   err_q <= 1'b0;
    else if (wd_expired) err_q <= 1'b1;
  end

  assign bus.res_err = err_q;
`else
  assign wd_expired  = 1'b0;
  assign bus.res_err = 1'b0;
`endif

  // FSM state and row counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  // Next-state logic and row counter advance
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          if (last_row) begin
            row_d   = '0;
            state_d = START;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      START:   state_d = WAIT;
      WAIT:    if (bus.sse_done || wd_expired) state_d = OUT;
      OUT:     if (bus.res_ready) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Write each accepted row into its slice. Old rows persist until overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (accept) begin
      a_q[ROW_W*row_q +: ROW_W] <= bus.in_src;
      b_q[ROW_W*row_q +: ROW_W] <= bus.in_pred;
    end
  end

  // Capture the engine result, or zero it on a watchdog abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             sse_q <= '0;
    else if (done_hit)   sse_q <= bus.sse_in;
    else if (wd_expired) sse_q <= '0;
  end

  // Handshake outputs decode directly from the state register
  assign bus.in_ready  = (state_q == FILL) && !rst;
  assign bus.sse_start = (state_q == START);
  assign bus.res_valid = (state_q == OUT);
  assign bus.busy      = (state_q != FILL);
  assign bus.sse_a     = a_q;
  assign bus.sse_b     = b_q;
  assign bus.res_sse   = sse_q;
endmodule
